// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns CPU load/store requests into lane-enabled,
// registered memory transactions with alignment checking, bus timeout and extended load return.
module mem_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signext,
  input  logic              cpu_if_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_stall,
  output logic              align_err,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_we,
  output logic              mem_re,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic              write_q, write_d;

  logic              stall, alignPulse, busPulse;
  logic              request, aligned, signBit;
  logic [OFFW-1:0]   reqOff, sizeMask;
  logic [NB-1:0]     laneWe;
  logic [DATA_W-1:0] laneWdata, loadShifted, extMask, loadExt;

  always_comb begin
    reqOff  = cpu_addr[OFFW-1:0];
    request = cpu_rd | cpu_wr;
    case (cpu_size)
      2'd0:    sizeMask = '0;
      2'd1:    sizeMask = OFFW'(1);
      2'd2:    sizeMask = OFFW'(3);
      default: sizeMask = OFFW'(7);
    endcase
    aligned = ((reqOff & sizeMask) == '0) && ((DATA_W == 64) || (cpu_size != 2'd3));
  end

  // Store lanes: the low 2^size bytes repeat across every lane; enables cover the addressed bytes.
  always_comb begin
    laneWe    = '0;
    laneWdata = '0;
    for (int i = 0; i < NB; i++) begin
      laneWe[i] = (i >= int'(reqOff)) && (i < int'(reqOff) + (1 << cpu_size));
      laneWdata[8*i +: 8] = cpu_wdata[8*(i & ((1 << cpu_size) - 1)) +: 8];
    end
  end

  always_comb begin
    loadShifted = mem_rdata >> {off_q, 3'b000};
    extMask     = '0;
    signBit     = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      extMask[i] = (i < (8 << size_q));
      if (i == (8 << size_q) - 1) signBit = loadShifted[i];
    end
    loadExt = loadShifted & extMask;
    if (sext_q && signBit) loadExt = loadExt | ~extMask;
  end

  always_comb begin
    state_d     = state_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = '0;
    mem_re_d    = 1'b0;
    cnt_d       = cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    sext_d      = sext_q;
    write_d     = write_q;
    stall       = 1'b0;
    alignPulse  = 1'b0;
    busPulse    = 1'b0;
    case (state_q)
      IDLE: begin
        if (request && aligned) begin
          state_d    = REQ;
          stall      = 1'b1;
          off_d      = reqOff;
          size_d     = cpu_size;
          sext_d     = cpu_signext;
          write_d    = cpu_wr;
          mem_addr_d = {cpu_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
          if (cpu_wr) begin
            mem_we_d    = laneWe;
            mem_wdata_d = laneWdata;
          end else begin
            mem_re_d = 1'b1;
          end
        end else if (request) begin
          state_d     = DONE;
          alignPulse  = 1'b1;
          cpu_rdata_d = '0;
        end
      end
      REQ: begin
        state_d = WAIT;
        stall   = 1'b1;
        cnt_d   = '0;
      end
      WAIT: begin
        stall = 1'b1;
        // The timeout fires in the MAX_WAIT-th WAIT cycle, i.e. once MAX_WAIT-1 cycles have elapsed.
        if (mem_ack) begin
          state_d = DONE;
          if (!write_q) cpu_rdata_d = loadExt;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          state_d     = DONE;
          busPulse    = 1'b1;
          cpu_rdata_d = '0;
        end else if (cnt_q != CW'(MAX_WAIT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!cpu_if_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cpu_rdata_q <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_re_q    <= 1'b0;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      write_q     <= write_d;
    end
  end

  // Combinational flags are masked during reset so a held request cannot leak through.
  assign mem_stall = stall & ~rst;
  assign align_err = alignPulse & ~rst;
  assign bus_err   = busPulse & ~rst;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (32-bit build, MAX_WAIT=4): directed cases
// followed by randomized transactions compared against an arithmetic reference model.
module tb_mem_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd, cpu_wr, cpu_signext, cpu_if_stall, mem_ack;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [1:0]    cpu_size;
  logic          mem_stall, align_err, bus_err, mem_re;
  logic [3:0]    mem_we;

  int            checks = 0;
  int            failures = 0;
  logic [31:0]   expRdata;

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_signext(cpu_signext),
    .cpu_if_stall(cpu_if_stall), .cpu_rdata(cpu_rdata), .mem_stall(mem_stall),
    .align_err(align_err), .bus_err(bus_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  function automatic bit expAligned(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b0;
    return (a % (32'd1 << s)) == 0;
  endfunction

  function automatic logic [3:0] expWe(input logic [31:0] a, input logic [1:0] s);
    int n = 1 << s;
    int off = int'(a % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] expWdata(input logic [31:0] d, input logic [1:0] s);
    int n = 8 << s;
    longint unsigned chunk = {32'd0, d} & ((64'd1 << n) - 1);
    longint unsigned res = 0;
    for (int k = 0; k < 32; k += n) res |= chunk << k;
    return 32'(res);
  endfunction

  function automatic logic [31:0] expLoad(input logic [31:0] r, input logic [31:0] a,
                                          input logic [1:0] s, input bit sx);
    int n = 8 << s;
    longint unsigned v = ({32'd0, r} >> (8 * (a % 4))) & ((64'd1 << n) - 1);
    if (sx && n < 32 && ((v >> (n - 1)) & 1) == 1) v |= ~((64'd1 << n) - 1);
    return 32'(v);
  endfunction

  // One complete transaction starting in IDLE; ackCycle=0 means memory never answers.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size, input bit sext,
                               input int ackCycle, input logic [31:0] rdataVal, input int holdCycles);
    bit store = wr;
    bit timedOut = 1'b0;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    cpu_size = size; cpu_signext = sext; mem_ack = 1'b0;
    #1;
    if (!expAligned(addr, size)) begin
      checkOutput("align_pulse", align_err, 1);
      checkOutput("align_nostall", mem_stall, 0);
      stepCycle;
      expRdata = 32'd0;
      checkOutput("align_once", align_err, 0);
      checkOutput("align_no_re", mem_re, 0);
      checkOutput("align_no_we", mem_we, 0);
      checkOutput("align_rdata", cpu_rdata, expRdata);
      checkOutput("align_done_stall", mem_stall, 0);
    end else begin
      checkOutput("req_stall", mem_stall, 1);
      checkOutput("req_no_align", align_err, 0);
      stepCycle;
      checkOutput("req_re", mem_re, !store);
      checkOutput("req_we", mem_we, store ? expWe(addr, size) : 4'd0);
      checkOutput("req_addr", mem_addr, addr & ~32'd3);
      if (store) checkOutput("req_wdata", mem_wdata, expWdata(wdata, size));
      checkOutput("req_stall2", mem_stall, 1);
      for (int w = 1; w <= MW; w++) begin
        stepCycle;
        checkOutput("wait_re_low", mem_re, 0);
        checkOutput("wait_we_low", mem_we, 0);
        checkOutput("wait_stall", mem_stall, 1);
        if (w == ackCycle) begin
          mem_ack = 1'b1;
          mem_rdata = rdataVal;
          #1;
          checkOutput("wait_no_bus", bus_err, 0);
          if (!store) expRdata = expLoad(rdataVal, addr, size, sext);
          break;
        end else if (w == MW) begin
          #1;
          checkOutput("timeout_bus", bus_err, 1);
          expRdata = 32'd0;
          timedOut = 1'b1;
        end else begin
          #1;
          checkOutput("wait_no_bus", bus_err, 0);
        end
      end
      stepCycle;
      mem_ack = 1'b0;
      checkOutput("done_stall", mem_stall, 0);
      checkOutput("done_bus", bus_err, 0);
      checkOutput("done_rdata", cpu_rdata, expRdata);
      if (timedOut) begin
        mem_ack = 1'b1;
        mem_rdata = ~rdataVal;
      end
    end
    if (holdCycles > 0) begin
      cpu_if_stall = 1'b1;
      for (int h = 0; h < holdCycles; h++) begin
        stepCycle;
        checkOutput("hold_stall", mem_stall, 0);
        checkOutput("hold_no_re", mem_re, 0);
        checkOutput("hold_no_we", mem_we, 0);
        checkOutput("hold_no_align", align_err, 0);
      end
    end
    cpu_if_stall = 1'b0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    stepCycle;
    checkOutput("idle_stall", mem_stall, 0);
    checkOutput("idle_rdata", cpu_rdata, expRdata);
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0;
    cpu_signext = 1'b0; cpu_if_stall = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    expRdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", mem_stall, 0);
    checkOutput("rst_re", mem_re, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_rdata", cpu_rdata, 0);
    checkOutput("rst_bus", bus_err, 0);
    checkOutput("rst_align", align_err, 0);
    rst = 1'b0;
    stepCycle;

    applyStimulus(1, 0, 32'h1003, 32'h0, 2'd0, 1, 1, 32'h80FF_0011, 0);
    checkOutput("tp_load_byte_sext", cpu_rdata, 32'hFFFF_FF80);
    applyStimulus(0, 1, 32'h2002, 32'h0000_BEEF, 2'd1, 0, 1, 32'h0, 0);
    applyStimulus(1, 0, 32'h3001, 32'h0, 2'd2, 0, 1, 32'h0, 0);
    checkOutput("tp_misaligned_rdata", cpu_rdata, 32'h0);
    applyStimulus(1, 0, 32'h4000, 32'h0, 2'd2, 0, 0, 32'h1234_5678, 0);
    applyStimulus(1, 0, 32'h5004, 32'h0, 2'd2, 0, 2, 32'hCAFE_0001, 5);
    checkOutput("tp_hold_load", cpu_rdata, 32'hCAFE_0001);
    applyStimulus(1, 1, 32'h6001, 32'h0000_005A, 2'd0, 0, 3, 32'hFFFF_FFFF, 0);
    applyStimulus(1, 0, 32'h7000, 32'h0, 2'd3, 0, 1, 32'h0, 0);
    applyStimulus(1, 0, 32'h7102, 32'h0, 2'd1, 0, 1, 32'h1234_ABCD, 0);

    // Abort a load mid-WAIT with the request still held.
    applyStimulus(1, 0, 32'h7200, 32'h0, 2'd2, 0, 1, 32'h0BAD_F00D, 0);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h8000; cpu_size = 2'd2; mem_ack = 1'b0;
    stepCycle;
    stepCycle;
    stepCycle;
    checkOutput("pre_rst_stall", mem_stall, 1);
    rst = 1'b1;
    #1;
    checkOutput("arst_stall", mem_stall, 0);
    checkOutput("arst_re", mem_re, 0);
    checkOutput("arst_we", mem_we, 0);
    checkOutput("arst_bus", bus_err, 0);
    checkOutput("arst_align", align_err, 0);
    checkOutput("arst_rdata", cpu_rdata, 0);
    checkOutput("arst_addr", mem_addr, 0);
    cpu_rd = 1'b0;
    stepCycle;
    rst = 1'b0;
    expRdata = 32'd0;
    stepCycle;
    checkOutput("post_rst_bus", bus_err, 0);

    for (int t = 0; t < 40; t++) begin
      bit rd = 1'($urandom_range(0, 1));
      bit wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(rd, wr, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, MW), $urandom, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
